// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared encodings for the instruction/data RAM arbiter.
package pipeline_pkg;

   // Arbiter FSM states; dbg_state exposes this encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   // Requester indices.
   localparam logic DEV_IF = 1'b0;
   localparam logic DEV_ID = 1'b1;

   // One-hot grant vector for a requester index.
   function automatic logic [1:0] dev_onehot(input logic dev);
      return dev ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way winner selection. A valid burst lock wins outright;
// otherwise a tie goes to the device that did not win last time.
// The output is only meaningful when req is non-zero or lock_valid is set.
module rr_pick2
   import pipeline_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       lock_valid,
   input  logic       lock_dev,
   output logic       winner
);

   // Lock first, then round-robin on a tie, then the single requester.
   always_comb begin
      winner = DEV_IF;
      if (lock_valid) begin
         winner = lock_dev;
      end else if (req[DEV_IF] && req[DEV_ID]) begin
         winner = ~last_grant;
      end else if (req[DEV_ID]) begin
         winner = DEV_ID;
      end else begin
         winner = DEV_IF;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single instruction/data RAM between device 0
// (instruction fetch, read-only) and device 1 (decoder, banked read/write).
//
// Handshake: a requester raises dev_en[i] with addr/di/we/bank stable and
// keeps them stable until dev_do_ack[i] pulses for one cycle; mem_do is
// valid in that ack cycle. dev_en is only looked at in IDLE, so a level
// still high in the first IDLE cycle after ACK is a new request.
module mem_arbiter
   import pipeline_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int BANK_W       = 4,
   parameter int READ_LATENCY = 1,
   parameter int MAX_BURST    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        dev_en,
   input  logic [1:0]        dev_we,
   input  logic [1:0]        dev_burst_en,
   input  logic [ADDR_W-1:0] dev0_addr,
   input  logic [DATA_W-1:0] dev0_di,
   input  logic [ADDR_W-1:0] dev1_addr,
   input  logic [DATA_W-1:0] dev1_di,
   input  logic [BANK_W-1:0] dev1_bank_select,
   output logic [1:0]        dev_do_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_di,
   output logic [BANK_W-1:0] mem_bank,
   output logic [1:0]        grant,
   output logic [1:0]        dbg_state
);

   // Last WAIT count before ACK, and the burst beat ceiling, at counter width.
   localparam logic [2:0] WAIT_LAST   = 3'(READ_LATENCY - 1);
   localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);
   localparam bit         SHORT_RD    = (READ_LATENCY == 1);

   state_t            state_q, state_d;
   logic [2:0]        wait_cnt_q, wait_cnt_d;
   logic              last_grant_q, last_grant_d;
   logic              owner_valid_q, owner_valid_d;
   logic              owner_q, owner_d;
   logic [3:0]        beat_q, beat_d;
   logic [1:0]        grant_q, grant_d;
   logic [1:0]        ack_q, ack_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_di_q, mem_di_d;
   logic [BANK_W-1:0] mem_bank_q, mem_bank_d;

   logic              other_req;
   logic              lock_ok;
   logic              winner;

   // Device 0 never writes and has no write data path.
   logic              unused_dev0;
   assign unused_dev0 = ^{dev0_di, dev_we[DEV_IF]};

   // The burst owner keeps the RAM while it still asks for a burst and has
   // beats left; once out of beats it only keeps going if the other side is quiet.
   assign other_req = dev_en[~owner_q];
   assign lock_ok   = owner_valid_q && dev_en[owner_q] && dev_burst_en[owner_q]
                      && ((beat_q < MAX_BURST_C) || !other_req);

   rr_pick2 u_pick (
      .req        (dev_en),
      .last_grant (last_grant_q),
      .lock_valid (lock_ok),
      .lock_dev   (owner_q),
      .winner     (winner)
   );

   // Next-state and next-output computation; mem_en, mem_we and ack are pulses.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      last_grant_d  = last_grant_q;
      owner_valid_d = owner_valid_q;
      owner_d       = owner_q;
      beat_d        = beat_q;
      grant_d       = grant_q;
      ack_d         = 2'b00;
      mem_en_d      = 1'b0;
      mem_we_d      = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_di_d      = mem_di_q;
      mem_bank_d    = mem_bank_q;

      unique case (state_q)
         ST_IDLE: begin
            if (|dev_en) begin
               state_d      = ST_ISSUE;
               mem_en_d     = 1'b1;
               grant_d      = dev_onehot(winner);
               last_grant_d = winner;
               if (winner == DEV_ID) begin
                  mem_we_d   = dev_we[DEV_ID];
                  mem_addr_d = dev1_addr;
                  mem_di_d   = dev1_di;
                  mem_bank_d = dev1_bank_select;
               end else begin
                  mem_we_d   = 1'b0;
                  mem_addr_d = dev0_addr;
                  mem_di_d   = '0;
                  mem_bank_d = '0;
               end
               if (lock_ok) begin
                  // Owner re-granted: next beat, or restart the count when
                  // it ran out of beats but nobody else is waiting.
                  beat_d = (beat_q < MAX_BURST_C) ? 4'(beat_q + 4'd1) : 4'd1;
               end else begin
                  // Fresh grant: the winner becomes owner only if it asks for a burst.
                  owner_valid_d = dev_burst_en[winner];
                  owner_d       = winner;
                  beat_d        = dev_burst_en[winner] ? 4'd1 : 4'd0;
               end
            end
         end
         ST_ISSUE: begin
            if (SHORT_RD) begin
               state_d = ST_ACK;
               ack_d   = grant_q;
            end else begin
               state_d    = ST_WAIT;
               wait_cnt_d = 3'd1;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_q == WAIT_LAST) begin
               state_d = ST_ACK;
               ack_d   = grant_q;
            end else begin
               wait_cnt_d = 3'(wait_cnt_q + 3'd1);
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   // All state and registered outputs; reset abandons any access in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         wait_cnt_q    <= 3'd0;
         last_grant_q  <= DEV_ID;
         owner_valid_q <= 1'b0;
         owner_q       <= DEV_IF;
         beat_q        <= 4'd0;
         grant_q       <= 2'b00;
         ack_q         <= 2'b00;
         mem_en_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_di_q      <= '0;
         mem_bank_q    <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         last_grant_q  <= last_grant_d;
         owner_valid_q <= owner_valid_d;
         owner_q       <= owner_d;
         beat_q        <= beat_d;
         grant_q       <= grant_d;
         ack_q         <= ack_d;
         mem_en_q      <= mem_en_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_di_q      <= mem_di_d;
         mem_bank_q    <= mem_bank_d;
      end
   end

   assign dev_do_ack = ack_q;
   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_di     = mem_di_q;
   assign mem_bank   = mem_bank_q;
   assign grant      = grant_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Instance "a" uses
// READ_LATENCY=1 and is checked by a scoreboard of expected RAM accesses;
// instance "b" uses READ_LATENCY=3 for latency and mid-access reset steps.
module tb_mem_arbiter;

   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int BW    = 4;
   localparam int RL_A  = 1;
   localparam int REC_W = 2 + 1 + AW + DW + BW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_a, rst_b;
   logic [1:0]    en_a, we_a, burst_a, en_b, we_b, burst_b;
   logic [AW-1:0] a0_a, a1_a, a0_b, a1_b;
   logic [DW-1:0] d0_a, d1_a, d0_b, d1_b;
   logic [BW-1:0] bank_a, bank_b;
   logic [1:0]    ack_a, grant_a, st_a, ack_b, grant_b, st_b;
   logic          mem_en_a, mem_we_a, mem_en_b, mem_we_b;
   logic [AW-1:0] mem_addr_a, mem_addr_b;
   logic [DW-1:0] mem_di_a, mem_di_b;
   logic [BW-1:0] mem_bank_a, mem_bank_b;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BANK_W(BW), .READ_LATENCY(RL_A), .MAX_BURST(4)) dut_a (
      .clk(clk), .reset(rst_a), .dev_en(en_a), .dev_we(we_a), .dev_burst_en(burst_a),
      .dev0_addr(a0_a), .dev0_di(d0_a), .dev1_addr(a1_a), .dev1_di(d1_a),
      .dev1_bank_select(bank_a), .dev_do_ack(ack_a), .mem_en(mem_en_a), .mem_we(mem_we_a),
      .mem_addr(mem_addr_a), .mem_di(mem_di_a), .mem_bank(mem_bank_a), .grant(grant_a),
      .dbg_state(st_a));

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BANK_W(BW), .READ_LATENCY(3), .MAX_BURST(4)) dut_b (
      .clk(clk), .reset(rst_b), .dev_en(en_b), .dev_we(we_b), .dev_burst_en(burst_b),
      .dev0_addr(a0_b), .dev0_di(d0_b), .dev1_addr(a1_b), .dev1_di(d1_b),
      .dev1_bank_select(bank_b), .dev_do_ack(ack_b), .mem_en(mem_en_b), .mem_we(mem_we_b),
      .mem_addr(mem_addr_b), .mem_di(mem_di_b), .mem_bank(mem_bank_b), .grant(grant_b),
      .dbg_state(st_b));

   int n_pass  = 0;
   int n_total = 0;

   logic [REC_W-1:0] exp_q[$];
   int               gap_q[$];
   int               pend_cnt   = 0;
   logic [1:0]       pend_grant = 2'b00;
   int               cyc        = 0;
   int               last_issue = -100;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
   endtask

   // gap = expected cycles since the previous mem_en (0 = not checked)
   task automatic push_a(input int gap, input logic [1:0] g, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] di,
                         input logic [BW-1:0] bank);
      exp_q.push_back({g, we, addr, di, bank});
      gap_q.push_back(gap);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Wait until every queued access of instance a has issued and acked.
   task automatic drain_a(input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while ((exp_q.size() != 0 || pend_cnt != 0) && n < 300);
      check({tag, "_drain"}, 64'(exp_q.size() == 0 && pend_cnt == 0), 64'd1);
      if (exp_q.size() != 0) begin
         exp_q.delete();
         gap_q.delete();
      end
      #1;
   endtask

   // Wait for mem_en (want_ack=0) or any ack (want_ack=1) on instance b.
   task automatic wait_b(input string tag, input bit want_ack, output int n);
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 30) begin
         @(negedge clk);
         n++;
         seen = want_ack ? (ack_b != 2'b00) : mem_en_b;
      end
      check({tag, "_seen"}, 64'(seen), 64'd1);
   endtask

   // Scoreboard for instance a: every mem_en pops one expected access, and
   // an ack for that device must follow exactly RL_A cycles later.
   initial begin : monitor
      logic [REC_W-1:0] got;
      logic [REC_W-1:0] expv;
      int               gap_exp;
      int               gap;
      bit               ack_due;
      forever begin
         @(negedge clk);
         cyc++;
         ack_due = 1'b0;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               ack_due = 1'b1;
               check("sb_ack", ack_a, pend_grant);
            end
         end
         if (!ack_due && ack_a != 2'b00) check("sb_spurious_ack", ack_a, 2'b00);
         if (!mem_en_a && mem_we_a) check("sb_we_without_en", mem_we_a, 1'b0);
         if (mem_en_a) begin
            gap        = cyc - last_issue;
            last_issue = cyc;
            check("sb_issue_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               expv    = exp_q.pop_front();
               gap_exp = gap_q.pop_front();
               got     = {grant_a, mem_we_a, mem_addr_a, mem_di_a, mem_bank_a};
               check("sb_issue", got, expv);
               if (gap_exp != 0) check("sb_gap", 64'(gap), 64'(gap_exp));
               pend_cnt   = RL_A;
               pend_grant = expv[REC_W-1 -: 2];
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end

   initial begin : stimulus
      int n;
      rst_a = 1'b0; rst_b = 1'b0;
      en_a = '0; we_a = '0; burst_a = '0; a0_a = '0; a1_a = '0; d0_a = '0; d1_a = '0; bank_a = '0;
      en_b = '0; we_b = '0; burst_b = '0; a0_b = '0; a1_b = '0; d0_b = '0; d1_b = '0; bank_b = '0;
      tick(3);

      // Reset state
      check("rst_grant_a", grant_a, 2'b00);
      check("rst_mem_en_a", mem_en_a, 1'b0);
      check("rst_mem_we_a", mem_we_a, 1'b0);
      check("rst_addr_a", mem_addr_a, '0);
      check("rst_di_a", mem_di_a, '0);
      check("rst_bank_a", mem_bank_a, '0);
      check("rst_ack_a", ack_a, 2'b00);
      check("rst_state_a", st_a, 2'd0);
      check("rst_grant_b", grant_b, 2'b00);
      check("rst_state_b", st_b, 2'd0);
      rst_a = 1'b1; rst_b = 1'b1;
      tick(2);

      // Single read from device 0 with latency check
      a0_a = 10'h005; d0_a = 32'hCAFE0000; en_a = 2'b01;
      push_a(0, 2'b01, 1'b0, 10'h005, 32'h0, 4'h0);
      @(negedge clk); check("rd_c0_en", mem_en_a, 1'b0);
      @(negedge clk); check("rd_c1_en", mem_en_a, 1'b1);
      check("rd_c1_addr", mem_addr_a, 10'h005);
      check("rd_c1_bank", mem_bank_a, 4'h0);
      @(negedge clk); check("rd_c2_ack", ack_a, 2'b01);
      drain_a("rd");
      en_a = 2'b00;
      check("rd_idle_grant", grant_a, 2'b00);
      check("rd_hold_addr", mem_addr_a, 10'h005);

      // Device 0 write request is forced to a read
      we_a = 2'b01; a0_a = 10'h123; en_a = 2'b01;
      push_a(0, 2'b01, 1'b0, 10'h123, 32'h0, 4'h0);
      drain_a("wr0");
      en_a = 2'b00; we_a = 2'b00;

      // Banked write from device 1
      we_a = 2'b10; a1_a = 10'h3FF; d1_a = 32'hDEADBEEF; bank_a = 4'hA; en_a = 2'b10;
      push_a(0, 2'b10, 1'b1, 10'h3FF, 32'hDEADBEEF, 4'hA);
      drain_a("wr1");
      en_a = 2'b00; we_a = 2'b00;

      // Both requesting continuously: strict alternation, 3 cycles apart
      a0_a = 10'h010; a1_a = 10'h020; d1_a = 32'h11; bank_a = 4'h3; en_a = 2'b11;
      push_a(0, 2'b01, 1'b0, 10'h010, 32'h0, 4'h0);
      push_a(3, 2'b10, 1'b0, 10'h020, 32'h11, 4'h3);
      push_a(3, 2'b01, 1'b0, 10'h010, 32'h0, 4'h0);
      push_a(3, 2'b10, 1'b0, 10'h020, 32'h11, 4'h3);
      drain_a("rr");
      en_a = 2'b00;

      // Burst lock: device 1 gets four beats, then device 0, then device 1 again
      burst_a = 2'b10; en_a = 2'b11;
      push_a(0, 2'b01, 1'b0, 10'h010, 32'h0, 4'h0);
      for (int i = 0; i < 4; i++) push_a(3, 2'b10, 1'b0, 10'h020, 32'h11, 4'h3);
      push_a(3, 2'b01, 1'b0, 10'h010, 32'h0, 4'h0);
      push_a(3, 2'b10, 1'b0, 10'h020, 32'h11, 4'h3);
      drain_a("burst");
      en_a = 2'b00;

      // Lone burst owner continues past the beat limit
      en_a = 2'b10;
      push_a(0, 2'b10, 1'b0, 10'h020, 32'h11, 4'h3);
      for (int i = 0; i < 5; i++) push_a(3, 2'b10, 1'b0, 10'h020, 32'h11, 4'h3);
      drain_a("burst_solo");
      en_a = 2'b00; burst_a = 2'b00;

      // Requester drops en right after issue: ack still arrives
      a0_a = 10'h0AA; en_a = 2'b01;
      push_a(0, 2'b01, 1'b0, 10'h0AA, 32'h0, 4'h0);
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (exp_q.size() != 0 && n < 50);
      #1;
      en_a = 2'b00;
      drain_a("drop");

      // READ_LATENCY=3: ack three cycles after mem_en, grant held through WAIT
      a1_b = 10'h02A; bank_b = 4'h5; d1_b = 32'h77; en_b = 2'b10;
      @(negedge clk); check("l3_c0_en", mem_en_b, 1'b0);
      @(negedge clk); check("l3_c1_en", mem_en_b, 1'b1);
      check("l3_c1_grant", grant_b, 2'b10);
      check("l3_c1_addr", mem_addr_b, 10'h02A);
      check("l3_c1_bank", mem_bank_b, 4'h5);
      check("l3_c1_di", mem_di_b, 32'h77);
      @(negedge clk); check("l3_c2_en", mem_en_b, 1'b0);
      check("l3_c2_grant", grant_b, 2'b10);
      check("l3_c2_state", st_b, 2'd2);
      check("l3_c2_ack", ack_b, 2'b00);
      @(negedge clk); check("l3_c3_grant", grant_b, 2'b10);
      check("l3_c3_ack", ack_b, 2'b00);
      @(negedge clk); check("l3_c4_ack", ack_b, 2'b10);
      check("l3_c4_grant", grant_b, 2'b10);
      @(posedge clk); #1;
      en_b = 2'b00;
      @(negedge clk); check("l3_c5_ack", ack_b, 2'b00);
      check("l3_c5_grant", grant_b, 2'b00);

      // Reset asserted during WAIT: outputs clear at once, no ack
      @(posedge clk); #1;
      en_b = 2'b10;
      wait_b("rstw_issue", 1'b0, n);
      @(negedge clk); check("rstw_state", st_b, 2'd2);
      rst_b = 1'b0;
      #1;
      check("rstw_grant", grant_b, 2'b00);
      check("rstw_mem_en", mem_en_b, 1'b0);
      check("rstw_addr", mem_addr_b, '0);
      check("rstw_di", mem_di_b, '0);
      check("rstw_bank", mem_bank_b, '0);
      check("rstw_state0", st_b, 2'd0);
      a0_b = 10'h0C3; en_b = 2'b11;
      repeat (3) begin
         @(negedge clk);
         check("rstw_no_ack", ack_b, 2'b00);
      end
      @(posedge clk); #1;
      rst_b = 1'b1;

      // After release, device 0 wins the tie, then device 1 is served
      wait_b("post_rst_issue0", 1'b0, n);
      check("post_rst_grant0", grant_b, 2'b01);
      check("post_rst_addr0", mem_addr_b, 10'h0C3);
      check("post_rst_bank0", mem_bank_b, 4'h0);
      wait_b("post_rst_ack0", 1'b1, n);
      check("post_rst_lat0", 64'(n), 64'd3);
      check("post_rst_ack0v", ack_b, 2'b01);
      @(posedge clk); #1;
      en_b = 2'b10;
      wait_b("post_rst_issue1", 1'b0, n);
      check("post_rst_grant1", grant_b, 2'b10);
      check("post_rst_addr1", mem_addr_b, 10'h02A);
      check("post_rst_bank1", mem_bank_b, 4'h5);
      wait_b("post_rst_ack1", 1'b1, n);
      check("post_rst_lat1", 64'(n), 64'd3);
      check("post_rst_ack1v", ack_b, 2'b10);
      @(posedge clk); #1;
      en_b = 2'b00;
      tick(3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single instruction/data RAM between two requesters: device 0 (instruction fetch, read-only) and device 1 (instruction decoder, read/write, banked).
- Each requester drives a level request; the arbiter grants one access at a time and drives the RAM port from registers.
- It returns a one-cycle do_ack per device, timed so that mem_do is valid in the ack cycle.
- Round-robin fairness, with optional burst lock so a requester can perform several back-to-back accesses.

Parameters:
- ADDR_W, 10, RAM word address width.
- DATA_W, 32, data width.
- BANK_W, 4, bank select width.
- READ_LATENCY, 1, cycles from mem_en to valid mem_do; legal values are 1 to 7.
- MAX_BURST, 4, maximum consecutive grants to one burst requester while the other requester waits; legal values are 1 to 15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- dev_en  in  2  per-device request level; bit0 = device 0 (IF), bit1 = device 1 (ID).
- dev_we  in  2  per-device write enable; bit0 is ignored and treated as 0.
- dev_burst_en  in  2  per-device burst hint.
- dev0_addr  in  ADDR_W  device 0 address.
- dev0_di  in  DATA_W  device 0 write data; unused.
- dev1_addr  in  ADDR_W  device 1 address.
- dev1_di  in  DATA_W  device 1 write data.
- dev1_bank_select  in  BANK_W  device 1 bank.
- dev_do_ack  out  2  one-cycle completion pulse per device.
- mem_en  out  1  RAM enable, one-cycle pulse per access.
- mem_we  out  1  RAM write enable; asserted only together with mem_en.
- mem_addr  out  ADDR_W  RAM address.
- mem_di  out  DATA_W  RAM write data.
- mem_bank  out  BANK_W  RAM bank; 0 for device 0.
- grant  out  2  one-hot owner of the current access; 0 when idle.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - All outputs = 0.
  - last_grant = 1, so device 0 wins the first tie.
  - Burst owner cleared; beat count = 0.
- States:
  - IDLE: sample dev_en. If any bit is set, select a winner, register addr/di/we/bank of the winner, go to ISSUE.
  - ISSUE (1 cycle): mem_en=1, mem_we=dev_we of winner, grant=one-hot winner. If READ_LATENCY=1 go to ACK, else go to WAIT.
  - WAIT: counts READ_LATENCY-1 cycles, then goes to ACK.
  - ACK (1 cycle): dev_do_ack[winner]=1 and mem_do is valid; go to IDLE.
- Latency: request first sampled high at edge N gives mem_en high during cycle N..N+1 and ack at cycle N+READ_LATENCY. Minimum spacing between accesses is READ_LATENCY+2 cycles.
- Requester rules:
  - Requester holds en, addr, di, we and bank stable until its ack.
  - dev_en is ignored in ISSUE, WAIT and ACK.
  - The first IDLE cycle after ACK treats en as a new request.
- Arbitration in IDLE:
  - If a burst owner exists, the owner still has en=1 and burst_en=1, and beat < MAX_BURST: grant the owner again and increment beat.
  - Otherwise, if both request: grant the device != last_grant.
  - Otherwise: grant the single requester.
  - On any non-burst grant: set owner = winner if its burst_en=1 (beat=1), else clear owner.
  - When beat reaches MAX_BURST and the other device is requesting, the other device wins, and owner/beat are reset as on a fresh grant.
  - When beat reaches MAX_BURST and the other device is idle, the owner continues with beat = 1.
  - last_grant updates on every grant.
- Write accesses follow the same timing: ack arrives READ_LATENCY cycles after mem_en.
- A write request from device 0 is forced to a read.
- Requester dropping en mid-access: the access completes and the ack is still pulsed.
- Registered outputs hold their values outside ISSUE; only mem_en, mem_we and dev_do_ack are pulses.
- Reset asserted mid-access: outputs clear immediately. No ack is emitted, and the access is lost.

Decomposition:
- Shared package pipeline_pkg holds:
  - state encoding constants ST_IDLE, ST_ISSUE, ST_WAIT, ST_ACK;
  - device index constants DEV_IF=0, DEV_ID=1.
- Sub-module rr_pick2 (combinational): inputs req[1:0], last_grant, lock_valid, lock_dev; output winner. It is reused for future requesters.

Test Plan:
- Single read: dev0 en, addr=0x005 from cycle 0, READ_LATENCY=1 -> mem_en=1 and mem_addr=0x005 in cycle 1; dev_do_ack=01 in cycle 2; mem_bank=0.
- Simultaneous requests: dev_en=11 held continuously -> grant sequence dev0, dev1, dev0, dev1; acks alternate with spacing of 3 cycles.
- Banked write: dev1 we=1, addr=0x3FF, di=0xDEADBEEF, bank=0xA -> one mem_en/mem_we pulse carrying those values; dev_do_ack=10 one cycle later. A dev_we[0]=1 request yields mem_we=0.
- Burst lock: dev1 burst_en=1 and dev0 requesting, MAX_BURST=4 -> four consecutive dev1 grants, then dev0 is granted, then dev1 resumes.
- Latency parameter: READ_LATENCY=3 -> ack three cycles after mem_en; grant held through WAIT.
- Reset mid-WAIT: reset low during WAIT -> all outputs 0 immediately. After release, a pending dev1 request is re-arbitrated with device 0 having priority on ties.
